// File: rtl/mem_bridge_pkg.sv
// Shared types for the core memory port: access sizes, MMIO register offsets and the alignment rule.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_addr_t;

  localparam logic [7:0] MMIO_TX     = 8'h00;
  localparam logic [7:0] MMIO_STATUS = 8'h04;
  localparam logic [7:0] MMIO_CYC_LO = 8'h08;
  localparam logic [7:0] MMIO_CYC_HI = 8'h0C;
  localparam logic [7:0] MMIO_EXIT   = 8'h10;

  // Only the two low address bits decide alignment.
  function automatic logic is_misaligned(input logic [1:0] addr, input mem_addr_t size);
    case (size)
      MEM_H, MEM_HU: return addr[0];
      MEM_W:         return addr != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DEPTH a power of 2; head is read straight from storage (no fall-through).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LEVEL);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/mem_bridge.sv
// Core memory port to word RAM + MMIO: lane steering and load extension are combinational (zero latency);
// console bytes go through a TX FIFO, overflowing pushes are dropped and flagged.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          RAM_AW     = 14,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_wren,
  input  logic [31:0]       mem_addr,
  input  mem_addr_t         mem_size,
  input  logic [31:0]       memwrite_data,
  output logic [31:0]       memread_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              host_exit,
  output logic [31:0]       exit_code,
  output logic              fault,
  output logic [31:0]       fault_addr
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          misaligned;
  logic          mmio_hit;
  logic          mmio_word;
  logic          mmio_wr;
  logic          mmio_rd;
  logic [7:0]    mmio_off;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_sh;
  logic [31:0]   load_ext;
  logic [31:0]   mmio_rdata;
  logic [63:0]   cyc_cnt;
  logic [31:0]   hi_shadow;
  logic          tx_overflow;
  logic          tx_push;
  logic          tx_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_head;

  assign misaligned = is_misaligned(mem_addr[1:0], mem_size);
  assign mmio_hit   = (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign mmio_off   = mem_addr[7:0];
  // Only aligned word accesses reach the MMIO registers.
  assign mmio_word  = mmio_hit & (mem_size == MEM_W) & ~misaligned & ~rst;
  assign mmio_wr    = mmio_word & mem_wren;
  assign mmio_rd    = mmio_word & mem_read;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = memwrite_data;
    case (mem_size)
      MEM_B, MEM_BU: begin
        lane_be    = 4'b0001 << mem_addr[1:0];
        lane_wdata = {4{memwrite_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        lane_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{memwrite_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_addr  = rst ? '0 : mem_addr[RAM_AW+1:2];
  assign ram_we    = mem_wren & ~misaligned & ~mmio_hit & ~rst;
  assign ram_be    = rst ? '0 : lane_be;
  assign ram_wdata = rst ? '0 : lane_wdata;

  always_comb begin
    lane_sh = ram_rdata >> {mem_addr[1:0], 3'b000};
    case (mem_size)
      MEM_B:   load_ext = {{24{lane_sh[7]}}, lane_sh[7:0]};
      MEM_BU:  load_ext = {24'h0, lane_sh[7:0]};
      MEM_H:   load_ext = {{16{lane_sh[15]}}, lane_sh[15:0]};
      MEM_HU:  load_ext = {16'h0, lane_sh[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      MMIO_STATUS: mmio_rdata = 32'({tx_overflow, fifo_full, fifo_level});
      MMIO_CYC_LO: mmio_rdata = cyc_cnt[31:0];
      MMIO_CYC_HI: mmio_rdata = hi_shadow;
      default:     ;
    endcase
  end

  always_comb begin
    if (rst)             memread_data = RESET_PC;
    else if (misaligned) memread_data = '0;
    else if (mmio_hit)   memread_data = mmio_word ? mmio_rdata : '0;
    else                 memread_data = load_ext;
  end

  assign tx_push  = mmio_wr & (mmio_off == MMIO_TX);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_head : 8'h00;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (memwrite_data[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt     <= '0;
      hi_shadow   <= '0;
      tx_overflow <= 1'b0;
      host_exit   <= 1'b0;
      exit_code   <= '0;
      fault       <= 1'b0;
      fault_addr  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      // Latching the upper half on the LO read keeps a later HI read coherent.
      if (mmio_rd && mmio_off == MMIO_CYC_LO) hi_shadow <= cyc_cnt[63:32];
      if (tx_push && fifo_full && !tx_pop)        tx_overflow <= 1'b1;
      else if (mmio_wr && mmio_off == MMIO_STATUS) tx_overflow <= 1'b0;
      if (mmio_wr && mmio_off == MMIO_EXIT) begin
        host_exit <= 1'b1;
        exit_code <= memwrite_data;
      end
      if ((mem_read || mem_wren) && misaligned) begin
        fault <= 1'b1;
        if (!fault) fault_addr <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: vector table, hand sequences and randomized runs against a reference model.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_wren = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  mem_addr_t   mem_size = MEM_W;
  logic [31:0] memwrite_data = 32'h0;
  logic [31:0] memread_data;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        host_exit;
  logic [31:0] exit_code;
  logic        fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  mem_bridge #(
    .RESET_PC   (32'h0000_0080),
    .RAM_AW     (14),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_wren      (mem_wren),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .memwrite_data (memwrite_data),
    .memread_data  (memread_data),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .host_exit     (host_exit),
    .exit_code     (exit_code),
    .fault         (fault),
    .fault_addr    (fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input mem_addr_t sz, input logic [31:0] d);
    mem_read      = rd;
    mem_wren      = wr;
    mem_addr      = a;
    mem_size      = sz;
    memwrite_data = d;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 32'h0, MEM_W, 32'h0);
  endtask

  task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
    drive(1'b0, 1'b1, {24'hFFFFFF, off}, MEM_W, d);
    tick;
    idle;
  endtask

  task automatic mmio_read(input logic [7:0] off, output logic [31:0] v);
    drive(1'b1, 1'b0, {24'hFFFFFF, off}, MEM_W, 32'h0);
    #1 v = memread_data;
    tick;
    idle;
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input mem_addr_t s, input logic [31:0] r);
    logic [31:0] v;
    int b;
    v = r >> ((a % 4) * 8);
    case (s)
      MEM_B:   begin b = int'(v % 256);   if (b >= 128)   b -= 256;   return 32'(b); end
      MEM_BU:  return v % 256;
      MEM_H:   begin b = int'(v % 65536); if (b >= 32768) b -= 65536; return 32'(b); end
      MEM_HU:  return v % 65536;
      default: return r;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] a, input mem_addr_t s);
    if (s == MEM_H || s == MEM_HU) return (a % 2) != 0;
    if (s == MEM_W) return (a % 4) != 0;
    return 1'b0;
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    mem_addr_t   size;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [31:0] e_rdata;
    logic        e_we;
    logic [13:0] e_raddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[13];
  mem_addr_t szs[5] = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
  mem_addr_t wszs[3] = '{MEM_B, MEM_H, MEM_W};

  initial begin
    logic [31:0] v;
    logic [7:0]  q[$];
    logic        ovf;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0103, MEM_B,  32'h0000_00A5, 32'hA500_0000, 32'hFFFF_FFA5, 1'b1, 14'h0040, 4'b1000, 32'hA5A5_A5A5};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0103, MEM_B,  32'h0,         32'hA500_0000, 32'hFFFF_FFA5, 1'b0, 14'h0040, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0103, MEM_BU, 32'h0,         32'hA500_0000, 32'h0000_00A5, 1'b0, 14'h0040, 4'b0000, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0102, MEM_H,  32'h0,         32'hA500_0000, 32'hFFFF_A500, 1'b0, 14'h0040, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0102, MEM_HU, 32'h0,         32'hA500_0000, 32'h0000_A500, 1'b0, 14'h0040, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0006, MEM_H,  32'h1234_BEEF, 32'h7FFF_0001, 32'h0000_7FFF, 1'b1, 14'h0001, 4'b1100, 32'hBEEF_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_FFFC, MEM_W,  32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 1'b1, 14'h3FFF, 4'b1111, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h0001_0001, MEM_B,  32'h0,         32'h0000_8000, 32'hFFFF_FF80, 1'b0, 14'h0000, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0002, MEM_B,  32'h0000_007F, 32'h0,         32'h0,         1'b1, 14'h0000, 4'b0100, 32'h7F7F_7F7F};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, MEM_H,  32'h0,         32'h1234_8001, 32'hFFFF_8001, 1'b0, 14'h0000, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FF40, MEM_W,  32'h1234_5678, 32'hFFFF_FFFF, 32'h0,         1'b0, 14'h3FD0, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FF00, MEM_B,  32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0, 14'h3FC0, 4'b0000, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0002_0002, MEM_HU, 32'h0,         32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 14'h0000, 4'b0000, 32'h0};

    // Reset: fetch returns RESET_PC whatever the address, nothing commits.
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, $urandom & 32'h0FFF_FFFF, MEM_W, $urandom);
      #1;
      chk("rst_rdata", memread_data, 32'h80);
      chk("rst_we", ram_we, 1'b0);
      tick;
    end
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_exit", host_exit, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_faddr", fault_addr, 32'h0);
    rst = 1'b0;
    idle;

    // Counter: 10 edges after reset release.
    repeat (10) tick;
    mmio_read(MMIO_CYC_LO, v);
    chk("cyc_count", v, 32'd10);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wd);
      ram_rdata = vecs[i].rdat;
      #1;
      chk($sformatf("vec%0d_rdata", i), memread_data, vecs[i].e_rdata);
      chk($sformatf("vec%0d_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_raddr", i), ram_addr, vecs[i].e_raddr);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_be", i), ram_be, vecs[i].e_be);
        chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].e_wdata);
      end
      tick;
    end
    idle;
    chk("no_fault_yet", fault, 1'b0);

    // Misalignment: first address sticks.
    drive(1'b0, 1'b1, 32'h102, MEM_W, 32'hFFFF_FFFF);
    #1 chk("mis_sw_we", ram_we, 1'b0);
    tick;
    chk("mis_fault", fault, 1'b1);
    chk("mis_faddr", fault_addr, 32'h102);
    drive(1'b1, 1'b0, 32'h201, MEM_H, 32'h0);
    ram_rdata = 32'hFFFF_FFFF;
    #1 chk("mis_lh_rdata", memread_data, 32'h0);
    tick;
    idle;
    chk("mis_faddr_hold", fault_addr, 32'h102);
    chk("mis_fault_hold", fault, 1'b1);

    // Randomized RAM-side accesses.
    for (int i = 0; i < 150; i++) begin
      logic        wr;
      logic [31:0] a, d, r;
      mem_addr_t   s;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom & 32'h7FFF_FFFF;
      d  = $urandom;
      r  = $urandom;
      s  = wr ? wszs[$urandom_range(0, 2)] : szs[$urandom_range(0, 4)];
      drive(~wr, wr, a, s, d);
      ram_rdata = r;
      #1;
      chk("rnd_rdata", memread_data, ref_misaligned(a, s) ? 32'h0 : ref_load(a, s, r));
      chk("rnd_we", ram_we, wr & ~ref_misaligned(a, s));
      chk("rnd_raddr", ram_addr, (a / 4) % 16384);
      if (wr && !ref_misaligned(a, s)) begin
        case (s)
          MEM_B: begin
            chk("rnd_be", ram_be, 32'd1 << (a % 4));
            chk("rnd_wdata", ram_wdata, (d % 256) * 32'h0101_0101);
          end
          MEM_H: begin
            chk("rnd_be", ram_be, 32'd3 << (a % 4));
            chk("rnd_wdata", ram_wdata, (d % 65536) * 32'h0001_0001);
          end
          default: begin
            chk("rnd_be", ram_be, 32'd15);
            chk("rnd_wdata", ram_wdata, d);
          end
        endcase
      end
      tick;
    end
    idle;

    // Overflow: nine pushes into an 8-deep FIFO with the sink stalled.
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) mmio_write(MMIO_TX, 32'(i));
    mmio_read(MMIO_STATUS, v);
    chk("ovf_status", v, 32'h38);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 8'(k));
      tick;
    end
    #1 chk("drain_empty", tx_valid, 1'b0);
    mmio_write(MMIO_STATUS, 32'h0);
    mmio_read(MMIO_STATUS, v);
    chk("ovf_cleared", v, 32'h0);

    // Push into empty with sink ready: no fall-through.
    drive(1'b0, 1'b1, 32'hFFFF_FF00, MEM_W, 32'h66);
    #1 chk("nofall_valid0", tx_valid, 1'b0);
    tick;
    idle;
    #1;
    chk("nofall_valid1", tx_valid, 1'b1);
    chk("nofall_data", tx_data, 8'h66);
    tick;
    #1 chk("nofall_gone", tx_valid, 1'b0);

    // Full FIFO, push and pop in the same cycle.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) mmio_write(MMIO_TX, 32'h11 + 32'(i));
    tx_ready = 1'b1;
    drive(1'b0, 1'b1, 32'hFFFF_FF00, MEM_W, 32'h55);
    tick;
    tx_ready = 1'b0;
    idle;
    mmio_read(MMIO_STATUS, v);
    chk("fullpp_status", v, 32'h18);
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fullpp_valid", tx_valid, 1'b1);
      chk("fullpp_data", tx_data, (k == 7) ? 8'h55 : 8'(8'h12 + k));
      tick;
    end
    #1 chk("fullpp_empty", tx_valid, 1'b0);

    // Randomized FIFO traffic against a queue model.
    ovf = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int   op;
      logic rdy, popped;
      logic [7:0] b;
      op  = $urandom_range(0, 5);
      rdy = ($urandom_range(0, 2) == 0);
      b   = 8'($urandom);
      tx_ready = rdy;
      case (op)
        0, 1, 2: drive(1'b0, 1'b1, 32'hFFFF_FF00, MEM_W, {24'h0, b});
        3:       drive(1'b1, 1'b0, 32'hFFFF_FF04, MEM_W, 32'h0);
        4:       drive(1'b0, 1'b1, 32'hFFFF_FF04, MEM_W, $urandom);
        default: idle;
      endcase
      #1;
      chk("rf_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) chk("rf_data", tx_data, q[0]);
      if (op == 3)
        chk("rf_status", memread_data,
            (32'(ovf) << 5) | (32'(q.size() == 8) << 4) | 32'(q.size()));
      tick;
      popped = (q.size() != 0) && rdy;
      if (popped) void'(q.pop_front());
      if (op <= 2) begin
        if (q.size() < 8) q.push_back(b);
        else ovf = 1'b1;
      end
      if (op == 4) ovf = 1'b0;
    end
    idle;
    tx_ready = 1'b1;
    repeat (10) tick;

    // Counter snapshot coherence.
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFE;
    mmio_read(MMIO_CYC_LO, v);
    release dut.cyc_cnt;
    chk("cyc_lo", v, 32'hFFFF_FFFE);
    repeat (3) tick;
    mmio_read(MMIO_CYC_HI, v);
    chk("cyc_hi_shadow", v, 32'h0);
    force dut.cyc_cnt = 64'h0000_0005_0000_0007;
    mmio_read(MMIO_CYC_LO, v);
    release dut.cyc_cnt;
    chk("cyc_lo2", v, 32'h7);
    repeat (2) tick;
    mmio_read(MMIO_CYC_HI, v);
    chk("cyc_hi2", v, 32'h5);

    // Host exit register.
    chk("exit_before", host_exit, 1'b0);
    mmio_write(MMIO_EXIT, 32'h2A);
    chk("exit_set", host_exit, 1'b1);
    chk("exit_code", exit_code, 32'h2A);
    repeat (3) tick;
    chk("exit_held", host_exit, 1'b1);
    mmio_write(MMIO_EXIT, 32'h77);
    chk("exit_code2", exit_code, 32'h77);
    chk("exit_held2", host_exit, 1'b1);

    // Reset mid-transfer with writes pending.
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) mmio_write(MMIO_TX, 32'hC0 + 32'(i));
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'hFFFF_FF00, MEM_W, 32'hEE);
    #1;
    chk("midrst_rdata", memread_data, 32'h80);
    chk("midrst_we", ram_we, 1'b0);
    tick;
    rst = 1'b0;
    idle;
    #1;
    chk("midrst_txv", tx_valid, 1'b0);
    chk("midrst_exit", host_exit, 1'b0);
    chk("midrst_code", exit_code, 32'h0);
    chk("midrst_fault", fault, 1'b0);
    mmio_read(MMIO_STATUS, v);
    chk("midrst_status", v, 32'h0);
    #1 chk("midrst_txv2", tx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
